// File: rtl/mcp_pkg.sv
// mcp_pkg: shared definitions for the multi-cycle RV32I control path.
// Holds the opcode constants, the datapath control-field encodings (shared
// with the single-cycle core), the FSM state encoding, the instruction class
// produced by the decoder and the bundle of registered control outputs.
package mcp_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // funct7 value selecting SUB / SRA
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_XOR    = 4'b0100,
        ALU_SLL    = 4'b0101,
        ALU_SRL    = 4'b0110,
        ALU_SRA    = 4'b0111,
        ALU_SLT    = 4'b1000,
        ALU_SLTU   = 4'b1001,
        ALU_OR     = 4'b1010,
        ALU_AND    = 4'b1011,
        ALU_PASS_B = 4'b1100
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_sel_e;

    typedef enum logic [1:0] {
        WB_MEM = 2'b00,
        WB_ALU = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_TRAP    = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ILLEGAL
    } instr_class_e;

    // Registered control outputs of the FSM, moved as one bundle.
    typedef struct packed {
        logic     mem_req;
        logic     mem_we;
        logic     mem_addr_sel;
        logic     pc_we;
        logic     pc_sel;
        imm_sel_e imm_sel;
        logic     a_sel;
        logic     b_sel;
        alu_op_e  alu_op;
        logic     reg_write;
        wb_sel_e  wb_sel;
        logic     instret;
    } ctrl_t;

    // Idle values: everything deasserted, writeback mux parked on the ALU.
    localparam ctrl_t CTRL_QUIET = '{
        mem_req:      1'b0,
        mem_we:       1'b0,
        mem_addr_sel: 1'b0,
        pc_we:        1'b0,
        pc_sel:       1'b0,
        imm_sel:      IMM_I,
        a_sel:        1'b0,
        b_sel:        1'b0,
        alu_op:       ALU_ADD,
        reg_write:    1'b0,
        wb_sel:       WB_ALU,
        instret:      1'b0
    };

    // funct3 010 and 011 are unassigned for branches.
    function automatic logic branch_funct3_legal(input logic [2:0] funct3);
        return funct3[2:1] != 2'b01;
    endfunction

endpackage

// File: rtl/mcp_controller_decoder.sv
// mcp_controller_decoder: purely combinational instruction decoder.
// Ports:
//   instr       in   32-bit instruction (IR contents)
//   alu_op      out  ALU operation
//   imm_sel     out  immediate format
//   a_sel       out  ALU operand A select (0 rs1, 1 PC)
//   b_sel       out  ALU operand B select (0 rs2, 1 immediate)
//   wb_sel      out  writeback source
//   instr_class out  alu / load / store / branch / jump / illegal
module mcp_controller_decoder
    import mcp_pkg::*;
(
    input  logic [31:0]  instr,
    output alu_op_e      alu_op,
    output imm_sel_e     imm_sel,
    output logic         a_sel,
    output logic         b_sel,
    output wb_sel_e      wb_sel,
    output instr_class_e instr_class
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       alt;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign alt    = (funct7 == F7_ALT);

    // Register and immediate fields are consumed by the datapath, not here.
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    // Immediate-form ALU ops have no SUB; funct7 only picks SRA there.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3,
                                                input logic       alt_f7,
                                                input logic       is_reg);
        case (f3)
            3'b000:  return (is_reg && alt_f7) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt_f7 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        alu_op      = ALU_ADD;
        imm_sel     = IMM_I;
        a_sel       = 1'b0;
        b_sel       = 1'b0;
        wb_sel      = WB_ALU;
        instr_class = CLS_ILLEGAL;
        case (opcode)
            OP_R: begin
                alu_op      = alu_from_funct3(funct3, alt, 1'b1);
                instr_class = CLS_ALU;
            end
            OP_I: begin
                alu_op      = alu_from_funct3(funct3, alt, 1'b0);
                b_sel       = 1'b1;
                instr_class = CLS_ALU;
            end
            OP_LOAD: begin
                b_sel       = 1'b1;
                wb_sel      = WB_MEM;
                instr_class = CLS_LOAD;
            end
            OP_STORE: begin
                imm_sel     = IMM_S;
                b_sel       = 1'b1;
                instr_class = CLS_STORE;
            end
            OP_BRANCH: begin
                imm_sel     = IMM_B;
                a_sel       = 1'b1;
                b_sel       = 1'b1;
                instr_class = CLS_BRANCH;
            end
            OP_JAL: begin
                imm_sel     = IMM_J;
                a_sel       = 1'b1;
                b_sel       = 1'b1;
                wb_sel      = WB_PC4;
                instr_class = CLS_JUMP;
            end
            OP_JALR: begin
                b_sel       = 1'b1;
                wb_sel      = WB_PC4;
                instr_class = CLS_JUMP;
            end
            OP_LUI: begin
                imm_sel     = IMM_U;
                b_sel       = 1'b1;
                alu_op      = ALU_PASS_B;
                instr_class = CLS_ALU;
            end
            OP_AUIPC: begin
                imm_sel     = IMM_U;
                a_sel       = 1'b1;
                b_sel       = 1'b1;
                instr_class = CLS_ALU;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mcp_controller.sv
// mcp_controller: multi-cycle control FSM for the RV32I multi-cycle core.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   instr_i                 IR contents
//   rs1_data_i, rs2_data_i  register-file read data (branch compare)
//   mem_ready_i             memory completes the pending request this cycle
//   mem_req_o, mem_we_o, mem_addr_sel_o   memory request controls
//   ir_we_o                 load IR (combinational on mem_ready_i in FETCH)
//   pc_we_o, pc_sel_o       PC update and source
//   imm_sel_o, a_sel_o, b_sel_o, alu_op_o, reg_write_o, wb_sel_o  datapath
//   state_o                 current state (debug)
//   illegal_o               sticky illegal-instruction trap
//   instret_o               one-cycle retire pulse
module mcp_controller
    import mcp_pkg::*;
#(
    parameter int X_LEN = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [X_LEN-1:0] instr_i,
    input  logic [X_LEN-1:0] rs1_data_i,
    input  logic [X_LEN-1:0] rs2_data_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             mem_addr_sel_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic             pc_sel_o,
    output logic [2:0]       imm_sel_o,
    output logic             a_sel_o,
    output logic             b_sel_o,
    output logic [3:0]       alu_op_o,
    output logic             reg_write_o,
    output logic [1:0]       wb_sel_o,
    output logic [2:0]       state_o,
    output logic             illegal_o,
    output logic             instret_o
);

    state_e       state;
    ctrl_t        ctrl_q;
    logic         illegal_q;

    alu_op_e      dec_alu_op;
    imm_sel_e     dec_imm_sel;
    logic         dec_a_sel;
    logic         dec_b_sel;
    wb_sel_e      dec_wb_sel;
    instr_class_e dec_class;

    logic [2:0]   funct3;
    logic         f3_ok;
    logic         taken;
    logic         store_done;
    ctrl_t        fetch_ctrl;
    ctrl_t        exec_ctrl;
    ctrl_t        mem_ctrl;
    ctrl_t        wb_ctrl;

    mcp_controller_decoder u_decoder (
        .instr       (instr_i[31:0]),
        .alu_op      (dec_alu_op),
        .imm_sel     (dec_imm_sel),
        .a_sel       (dec_a_sel),
        .b_sel       (dec_b_sel),
        .wb_sel      (dec_wb_sel),
        .instr_class (dec_class)
    );

    function automatic logic branch_taken(input logic [2:0]       f3,
                                          input logic [X_LEN-1:0] a,
                                          input logic [X_LEN-1:0] b);
        logic signed [X_LEN-1:0] sa;
        logic signed [X_LEN-1:0] sb;
        sa = a;
        sb = b;
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return sa < sb;
            3'b101:  return sa >= sb;
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    assign funct3 = instr_i[14:12];
    assign f3_ok  = branch_funct3_legal(funct3);
    assign taken  = branch_taken(funct3, rs1_data_i, rs2_data_i);

    // Control bundles loaded on entry to each state. The IR and register
    // operands are stable from DECODE onward, so EXECUTE outputs (including
    // the branch decision) can be registered on the DECODE edge.
    always_comb begin
        fetch_ctrl         = CTRL_QUIET;
        fetch_ctrl.mem_req = 1'b1;

        exec_ctrl          = CTRL_QUIET;
        exec_ctrl.alu_op   = dec_alu_op;
        exec_ctrl.imm_sel  = dec_imm_sel;
        exec_ctrl.a_sel    = dec_a_sel;
        exec_ctrl.b_sel    = dec_b_sel;
        if (dec_class == CLS_BRANCH && f3_ok) begin
            exec_ctrl.pc_we   = 1'b1;
            exec_ctrl.pc_sel  = taken;
            exec_ctrl.instret = 1'b1;
        end

        mem_ctrl              = exec_ctrl;
        mem_ctrl.pc_we        = 1'b0;
        mem_ctrl.pc_sel       = 1'b0;
        mem_ctrl.instret      = 1'b0;
        mem_ctrl.mem_req      = 1'b1;
        mem_ctrl.mem_addr_sel = 1'b1;
        mem_ctrl.mem_we       = (dec_class == CLS_STORE);

        wb_ctrl           = exec_ctrl;
        wb_ctrl.reg_write = 1'b1;
        wb_ctrl.pc_we     = 1'b1;
        wb_ctrl.instret   = 1'b1;
        wb_ctrl.wb_sel    = dec_wb_sel;
        wb_ctrl.pc_sel    = (dec_class == CLS_JUMP);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            ctrl_q    <= CTRL_QUIET;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state  <= ST_FETCH;
                    ctrl_q <= fetch_ctrl;
                end
                ST_FETCH: begin
                    if (mem_ready_i) begin
                        state  <= ST_DECODE;
                        ctrl_q <= CTRL_QUIET;
                    end
                end
                ST_DECODE: begin
                    if (dec_class == CLS_ILLEGAL) begin
                        state     <= ST_TRAP;
                        ctrl_q    <= CTRL_QUIET;
                        illegal_q <= 1'b1;
                    end else begin
                        state  <= ST_EXECUTE;
                        ctrl_q <= exec_ctrl;
                    end
                end
                ST_EXECUTE: begin
                    case (dec_class)
                        CLS_BRANCH: begin
                            if (f3_ok) begin
                                state  <= ST_FETCH;
                                ctrl_q <= fetch_ctrl;
                            end else begin
                                state     <= ST_TRAP;
                                ctrl_q    <= CTRL_QUIET;
                                illegal_q <= 1'b1;
                            end
                        end
                        CLS_LOAD, CLS_STORE: begin
                            state  <= ST_MEM;
                            ctrl_q <= mem_ctrl;
                        end
                        default: begin
                            state  <= ST_WB;
                            ctrl_q <= wb_ctrl;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready_i) begin
                        if (dec_class == CLS_STORE) begin
                            state  <= ST_FETCH;
                            ctrl_q <= fetch_ctrl;
                        end else begin
                            state  <= ST_WB;
                            ctrl_q <= wb_ctrl;
                        end
                    end
                end
                ST_WB: begin
                    state  <= ST_FETCH;
                    ctrl_q <= fetch_ctrl;
                end
                ST_TRAP: ;
                default: begin
                    state  <= ST_IDLE;
                    ctrl_q <= CTRL_QUIET;
                end
            endcase
        end
    end

    // A store retires in the cycle its memory write is accepted, so its PC
    // update and retire pulse follow mem_ready_i directly.
    assign store_done = (state == ST_MEM) && mem_ready_i && (dec_class == CLS_STORE);

    assign mem_req_o      = ctrl_q.mem_req;
    assign mem_we_o       = ctrl_q.mem_we;
    assign mem_addr_sel_o = ctrl_q.mem_addr_sel;
    assign ir_we_o        = (state == ST_FETCH) && mem_ready_i;
    assign pc_we_o        = ctrl_q.pc_we | store_done;
    assign pc_sel_o       = ctrl_q.pc_sel;
    assign imm_sel_o      = ctrl_q.imm_sel;
    assign a_sel_o        = ctrl_q.a_sel;
    assign b_sel_o        = ctrl_q.b_sel;
    assign alu_op_o       = ctrl_q.alu_op;
    assign reg_write_o    = ctrl_q.reg_write;
    assign wb_sel_o       = ctrl_q.wb_sel;
    assign instret_o      = ctrl_q.instret | store_done;
    assign state_o        = state;
    assign illegal_o      = illegal_q;

endmodule

// File: tb/tb_mcp_controller.sv
// tb_mcp_controller: scoreboard bench for mcp_controller. Each instruction
// pushes its expected per-cycle output pattern (with the mem_ready value to
// drive that cycle) onto a queue; the queue is then drained cycle by cycle
// and every entry compared against the DUT.
module tb_mcp_controller;

    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_R      = 7'b0110011;
    localparam logic [6:0] T_I      = 7'b0010011;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [31:0] rs1 = 32'h0;
    logic [31:0] rs2 = 32'h0;
    logic        ready = 1'b0;

    logic        mem_req_o, mem_we_o, mem_addr_sel_o, ir_we_o, pc_we_o, pc_sel_o;
    logic [2:0]  imm_sel_o;
    logic        a_sel_o, b_sel_o;
    logic [3:0]  alu_op_o;
    logic        reg_write_o;
    logic [1:0]  wb_sel_o;
    logic [2:0]  state_o;
    logic        illegal_o, instret_o;

    mcp_controller #(.X_LEN(32)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .instr_i        (instr),
        .rs1_data_i     (rs1),
        .rs2_data_i     (rs2),
        .mem_ready_i    (ready),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_sel_o (mem_addr_sel_o),
        .ir_we_o        (ir_we_o),
        .pc_we_o        (pc_we_o),
        .pc_sel_o       (pc_sel_o),
        .imm_sel_o      (imm_sel_o),
        .a_sel_o        (a_sel_o),
        .b_sel_o        (b_sel_o),
        .alu_op_o       (alu_op_o),
        .reg_write_o    (reg_write_o),
        .wb_sel_o       (wb_sel_o),
        .state_o        (state_o),
        .illegal_o      (illegal_o),
        .instret_o      (instret_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rdy;
        logic [2:0] st;
        logic       req, we, asel, irwe, pcwe, instret, regw, ill;
        logic       pcsel;
        logic       chk_pcsel;
        logic [3:0] alu;
        logic       chk_alu;
        logic [1:0] wb;
        logic       chk_wb;
    } ent_t;

    ent_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t blank(input logic [2:0] st, input logic rdy);
        ent_t e;
        e.rdy = rdy; e.st = st;
        e.req = 0; e.we = 0; e.asel = 0; e.irwe = 0; e.pcwe = 0;
        e.instret = 0; e.regw = 0; e.ill = 0;
        e.pcsel = 0; e.chk_pcsel = 0;
        e.alu = 4'h0; e.chk_alu = 0;
        e.wb = 2'b01; e.chk_wb = 0;
        return e;
    endfunction

    // Drain the scoreboard: drive this cycle's ready, settle, compare, advance.
    task automatic drain(input string name);
        ent_t e;
        int   c;
        c = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            ready = e.rdy;
            #1;
            chk($sformatf("%s.c%0d.state", name, c), state_o, e.st);
            chk($sformatf("%s.c%0d.mem_req", name, c), mem_req_o, e.req);
            chk($sformatf("%s.c%0d.mem_we", name, c), mem_we_o, e.we);
            chk($sformatf("%s.c%0d.addr_sel", name, c), mem_addr_sel_o, e.asel);
            chk($sformatf("%s.c%0d.ir_we", name, c), ir_we_o, e.irwe);
            chk($sformatf("%s.c%0d.pc_we", name, c), pc_we_o, e.pcwe);
            chk($sformatf("%s.c%0d.instret", name, c), instret_o, e.instret);
            chk($sformatf("%s.c%0d.reg_write", name, c), reg_write_o, e.regw);
            chk($sformatf("%s.c%0d.illegal", name, c), illegal_o, e.ill);
            if (e.chk_pcsel) chk($sformatf("%s.c%0d.pc_sel", name, c), pc_sel_o, e.pcsel);
            if (e.chk_alu)   chk($sformatf("%s.c%0d.alu_op", name, c), alu_op_o, e.alu);
            if (e.chk_wb)    chk($sformatf("%s.c%0d.wb_sel", name, c), wb_sel_o, e.wb);
            c++;
            @(negedge clk);
        end
    endtask

    // Called at a negedge; reset is asserted between clock edges so the
    // return to IDLE must be asynchronous.
    task automatic do_reset(input string name);
        ent_t e;
        rst_ni = 1'b0;
        ready  = 1'b1;
        #1;
        chk({name, ".rst.state"}, state_o, 3'd0);
        chk({name, ".rst.illegal"}, illegal_o, 1'b0);
        chk({name, ".rst.mem_req"}, mem_req_o, 1'b0);
        chk({name, ".rst.ir_we"}, ir_we_o, 1'b0);
        chk({name, ".rst.pc_we"}, pc_we_o, 1'b0);
        chk({name, ".rst.wb_sel"}, wb_sel_o, 2'b01);
        @(negedge clk);
        rst_ni = 1'b1;
        e = blank(3'd0, 1'b0);
        e.chk_wb = 1; e.chk_alu = 1; e.chk_pcsel = 1;
        sbq.push_back(e);
        drain({name, ".idle"});
    endtask

    task automatic run_instr(input string name, input logic [31:0] ins,
                             input logic [31:0] a, input logic [31:0] b,
                             input int fw, input int mw,
                             input logic [3:0] alu, input logic tkn);
        ent_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        logic       legal, is_ld, is_st, is_br, is_jmp;
        op = ins[6:0];
        f3 = ins[14:12];
        is_ld  = (op == T_LOAD);
        is_st  = (op == T_STORE);
        is_br  = (op == T_BRANCH);
        is_jmp = (op == T_JAL) || (op == T_JALR);
        legal  = is_ld || is_st || is_br || is_jmp || op == T_R || op == T_I ||
                 op == T_LUI || op == T_AUIPC;
        instr = ins; rs1 = a; rs2 = b;

        for (int i = 0; i < fw; i++) begin
            e = blank(3'd1, 1'b0); e.req = 1; sbq.push_back(e);
        end
        e = blank(3'd1, 1'b1); e.req = 1; e.irwe = 1; sbq.push_back(e);
        e = blank(3'd2, 1'b1); sbq.push_back(e);
        if (!legal) begin
            for (int i = 0; i < 20; i++) begin
                e = blank(3'd6, 1'b1); e.ill = 1; sbq.push_back(e);
            end
            drain(name);
            return;
        end
        e = blank(3'd3, 1'b1); e.alu = alu; e.chk_alu = 1;
        if (is_br) begin
            if (f3 == 3'b010 || f3 == 3'b011) begin
                sbq.push_back(e);
                for (int i = 0; i < 3; i++) begin
                    e = blank(3'd6, 1'b1); e.ill = 1; sbq.push_back(e);
                end
            end else begin
                e.pcwe = 1; e.instret = 1; e.pcsel = tkn; e.chk_pcsel = 1;
                sbq.push_back(e);
            end
            drain(name);
            return;
        end
        sbq.push_back(e);
        if (is_ld || is_st) begin
            for (int i = 0; i < mw; i++) begin
                e = blank(3'd4, 1'b0); e.req = 1; e.asel = 1; e.we = is_st;
                e.alu = alu; e.chk_alu = 1; sbq.push_back(e);
            end
            e = blank(3'd4, 1'b1); e.req = 1; e.asel = 1; e.we = is_st;
            e.alu = alu; e.chk_alu = 1;
            if (is_st) begin
                e.pcwe = 1; e.instret = 1; e.pcsel = 0; e.chk_pcsel = 1;
            end
            sbq.push_back(e);
        end
        if (!is_st) begin
            e = blank(3'd5, 1'b1); e.regw = 1; e.pcwe = 1; e.instret = 1;
            e.wb = is_ld ? 2'b00 : (is_jmp ? 2'b10 : 2'b01); e.chk_wb = 1;
            e.pcsel = is_jmp; e.chk_pcsel = 1;
            e.alu = alu; e.chk_alu = 1;
            sbq.push_back(e);
        end
        drain(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset("por");
        run_instr("add",   32'h002081B3, 32'd1, 32'd2, 0, 0, 4'b0000, 1'b0);
        run_instr("lw_w3", 32'h00012083, 32'd0, 32'd0, 0, 3, 4'b0000, 1'b0);
        run_instr("beq_t", 32'h00208063, 32'd5, 32'd5, 0, 0, 4'b0000, 1'b1);
        run_instr("beq_n", 32'h00208063, 32'd5, 32'd6, 0, 0, 4'b0000, 1'b0);
        run_instr("bltu",  32'h0020E063, 32'hFFFFFFFF, 32'd1, 0, 0, 4'b0000, 1'b0);
        run_instr("blt",   32'h0020C063, 32'hFFFFFFFF, 32'd1, 0, 0, 4'b0000, 1'b1);
        run_instr("sw",    32'h0020A023, 32'd0, 32'd0, 0, 0, 4'b0000, 1'b0);
        run_instr("sub",   32'h402081B3, 32'd0, 32'd0, 0, 0, 4'b0001, 1'b0);
        run_instr("sltu",  32'h0020B1B3, 32'd0, 32'd0, 0, 0, 4'b1001, 1'b0);
        run_instr("and",   32'h0020F1B3, 32'd0, 32'd0, 0, 0, 4'b1011, 1'b0);
        run_instr("sra",   32'h4020D1B3, 32'd0, 32'd0, 0, 0, 4'b0111, 1'b0);
        run_instr("srai",  32'h4030D193, 32'd0, 32'd0, 0, 0, 4'b0111, 1'b0);
        run_instr("xori",  32'h0040C193, 32'd0, 32'd0, 0, 0, 4'b0100, 1'b0);
        run_instr("addi_hi", 32'h40008193, 32'd0, 32'd0, 0, 0, 4'b0000, 1'b0);
        run_instr("addi_fw", 32'h00108193, 32'd0, 32'd0, 2, 0, 4'b0000, 1'b0);
        run_instr("lui",   32'h123451B7, 32'd0, 32'd0, 0, 0, 4'b1100, 1'b0);
        run_instr("jal",   32'h000000EF, 32'd0, 32'd0, 0, 0, 4'b0000, 1'b0);
        run_instr("jalr",  32'h000100E7, 32'd0, 32'd0, 0, 0, 4'b0000, 1'b0);
        run_instr("auipc", 32'h00000197, 32'd0, 32'd0, 0, 0, 4'b0000, 1'b0);
        run_instr("lw_w1", 32'h00012083, 32'd0, 32'd0, 1, 1, 4'b0000, 1'b0);
        run_instr("sw_w2", 32'h0020A023, 32'd0, 32'd0, 0, 2, 4'b0000, 1'b0);

        run_instr("ill7f", 32'h0000007F, 32'd0, 32'd0, 0, 0, 4'b0000, 1'b0);
        do_reset("trap_rst");
        run_instr("add2",  32'h002081B3, 32'd1, 32'd2, 0, 0, 4'b0000, 1'b0);

        run_instr("bf3",   32'h0020A063, 32'd1, 32'd1, 0, 0, 4'b0000, 1'b0);
        do_reset("bf3_rst");

        // Reset in the middle of a FETCH wait, with ready rising at the same time.
        ready = 1'b0;
        #1;
        chk("midf.wait0.state", state_o, 3'd1);
        chk("midf.wait0.mem_req", mem_req_o, 1'b1);
        chk("midf.wait0.ir_we", ir_we_o, 1'b0);
        @(negedge clk);
        #1;
        chk("midf.wait1.state", state_o, 3'd1);
        #1;
        rst_ni = 1'b0;
        ready  = 1'b1;
        #1;
        chk("midf.rst.state", state_o, 3'd0);
        chk("midf.rst.mem_req", mem_req_o, 1'b0);
        chk("midf.rst.ir_we", ir_we_o, 1'b0);
        chk("midf.rst.pc_we", pc_we_o, 1'b0);
        @(negedge clk);
        #1;
        chk("midf.hold.ir_we", ir_we_o, 1'b0);
        chk("midf.hold.state", state_o, 3'd0);
        @(negedge clk);
        do_reset("midf_rel");
        run_instr("add3",  32'h002081B3, 32'd1, 32'd2, 0, 0, 4'b0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mcp_controller.md
Name: mcp_controller

Overview:
- Multi-cycle control FSM for the RV32I multi-cycle core.
- Sequences one shared instruction/data memory, the IR, the PC, the ALU, the register file and the writeback mux, one instruction at a time.
- Control-field encodings (imm_sel, alu_op, wb_sel, a/b_sel) are identical to the single-cycle core, so the datapath blocks are reused unchanged.
- Adds a memory ready handshake, per-instruction state sequencing and a sticky illegal-instruction trap.

Parameters:
- X_LEN, 32, datapath width of rs1/rs2 compare operands and instruction.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- instr_i  in  X_LEN  current IR contents (external register, loaded by ir_we_o)
- rs1_data_i  in  X_LEN  register-file read data 1, used for branch compare
- rs2_data_i  in  X_LEN  register-file read data 2
- mem_ready_i  in  1  memory accepts/completes the pending request this cycle
- mem_req_o  out  1  memory request valid
- mem_we_o  out  1  request is a store
- mem_addr_sel_o  out  1  0 = PC, 1 = ALU result
- ir_we_o  out  1  load IR from memory read data
- pc_we_o  out  1  update PC this cycle
- pc_sel_o  out  1  0 = PC+4, 1 = ALU result
- imm_sel_o  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- a_sel_o  out  1  0 = rs1, 1 = PC
- b_sel_o  out  1  0 = rs2, 1 = immediate
- alu_op_o  out  4  ADD 0000, SUB 0001, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, OR 1010, AND 1011, PASS_B 1100
- reg_write_o  out  1  register-file write enable
- wb_sel_o  out  2  00 mem data, 01 ALU, 10 PC+4
- state_o  out  3  current state, for debug/verification
- illegal_o  out  1  sticky trap flag
- instret_o  out  1  one-cycle pulse when an instruction retires

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, TRAP=6.
- Reset (async assert): state=IDLE, illegal_o=0. All outputs are 0 in IDLE, except wb_sel_o=01.
- IDLE -> FETCH unconditionally on the first clock after reset release.
- Reset asserted mid-instruction aborts immediately; no pending write completes.
- FETCH: mem_req_o=1, mem_addr_sel_o=0, mem_we_o=0. All three are held stable until mem_ready_i=1.
  - In the ready cycle: ir_we_o=1 (combinational on mem_ready_i), then -> DECODE.
  - While not ready: stay in FETCH, ir_we_o=0.
- DECODE: decode the opcode.
  - Legal opcodes (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111) -> EXECUTE.
  - Any other opcode -> TRAP.
- EXECUTE: drive ALU controls for the opcode.
  - R-type/I-type ALU: ops as encoded above. SUB/SRA when funct7=0100000; for I-type, SRA only.
  - Load/store/JALR: ADD, b_sel=1.
  - Branch, JAL, AUIPC: a_sel=1, b_sel=1, ADD.
  - LUI: PASS_B, imm U.
  - Branch retires here: pc_we_o=1, pc_sel_o=taken, instret_o=1 -> FETCH.
    - Taken is computed from rs1/rs2: BEQ/BNE/BLT/BGE signed; BLTU/BGEU unsigned.
    - funct3 010/011 -> TRAP.
  - Load/store -> MEM. All others -> WB.
- MEM: mem_req_o=1, mem_addr_sel_o=1, mem_we_o=store. ALU controls held from EXECUTE; wait for mem_ready_i.
  - Store retires on ready: pc_we_o=1, pc_sel_o=0, instret_o=1 -> FETCH.
  - Load -> WB on ready.
- WB: reg_write_o=1, ALU controls held, pc_we_o=1, instret_o=1 -> FETCH.
  - wb_sel: load 00; JAL/JALR 10; others 01.
  - pc_sel_o=1 for JAL/JALR, else 0.
- TRAP: illegal_o=1. No req, no writes; remain in TRAP until reset.
- Exactly one pc_we_o and one instret_o pulse per retired instruction.
- Minimum latencies with zero-wait memory:
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles (F,D,E,WB).
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each memory wait cycle adds 1 to latency.
- mem_ready_i outside FETCH/MEM is ignored.

Decomposition:
- Package mcp_pkg:
  - Opcode constants.
  - alu_op_e, imm_sel_e, wb_sel_e, state_e enums.
- Sub-module mcp_decoder: purely combinational instr_i -> {alu_op, imm_sel, a_sel, b_sel, wb_sel, class (alu/load/store/branch/jump/illegal)}.
- mcp_controller holds the FSM, handshake, branch compare and output gating.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), ready always 1 -> states 1,2,3,5,1; reg_write_o=1 only in WB; alu_op=0000; instret_o one pulse at cycle 4.
- LW with ready low 3 cycles in MEM -> mem_req_o/mem_addr_sel_o=1 stable 4 cycles; then WB with wb_sel_o=00; total 8 cycles.
- BEQ with rs1=rs2=5 -> EXECUTE: pc_we_o=1, pc_sel_o=1. With rs1=5, rs2=6 -> pc_sel_o=0. BLTU with rs1=0xFFFFFFFF, rs2=1 -> not taken; BLT with the same operands -> taken.
- SW with ready 1 -> MEM: mem_we_o=1; reg_write_o never asserted; instret_o pulses in MEM.
- Opcode 0x7F -> DECODE -> TRAP; illegal_o=1 persists 20 cycles; mem_req_o=0. rst_ni low then high -> IDLE, illegal_o=0, FETCH next cycle.
- rst_ni asserted in the middle of a FETCH wait -> outputs drop asynchronously to reset values; no ir_we_o pulse.
